// File: rtl/instr_register_pipe.sv
// rtl/instr_register_pipe.sv - instruction register with registered ALU stage, valid tracking and registered read port
//
// Purpose:
//   Accepts one write per cycle (opcode + two signed operands). The write is
//   captured into stage 1, the ALU result is computed from stage 1 and the
//   entry is committed one edge later. Per-entry valid bits, occupancy and
//   bulk clear are tracked. Reads are registered with a one-cycle valid pulse.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   load_en, write_pointer      write request and address
//   opcode, operand_a/b         instruction fields (operands signed)
//   clear_en                    invalidate all entries
//   rd_en, read_pointer         read request and address
//   rd_valid, rd_hit            read strobe, addressed entry was valid
//   rd_opcode/operand_a/b       stored instruction fields
//   rd_result, rd_div0          stored ALU result and divide-by-zero flag
//   entry_count, full           occupancy
module instr_register_pipe #(
  parameter int DEPTH = 32,
  parameter int OP_W  = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int RES_W = 2 * OP_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_en,
  input  logic [AW-1:0]           write_pointer,
  input  logic [2:0]              opcode,
  input  logic [OP_W-1:0]         operand_a,
  input  logic [OP_W-1:0]         operand_b,
  input  logic                    clear_en,
  input  logic                    rd_en,
  input  logic [AW-1:0]           read_pointer,
  output logic                    rd_valid,
  output logic                    rd_hit,
  output logic [2:0]              rd_opcode,
  output logic [OP_W-1:0]         rd_operand_a,
  output logic [OP_W-1:0]         rd_operand_b,
  output logic [RES_W-1:0]        rd_result,
  output logic                    rd_div0,
  output logic [AW:0]             entry_count,
  output logic                    full
);

  typedef enum logic [2:0] {
    OP_ZERO  = 3'd0,
    OP_PASSA = 3'd1,
    OP_PASSB = 3'd2,
    OP_ADD   = 3'd3,
    OP_SUB   = 3'd4,
    OP_MULT  = 3'd5,
    OP_DIV   = 3'd6,
    OP_MOD   = 3'd7
  } opcode_e;

  // Stage 1: captured write request
  logic            s1_valid;
  logic [AW-1:0]   s1_ptr;
  logic [2:0]      s1_opcode;
  logic [OP_W-1:0] s1_a;
  logic [OP_W-1:0] s1_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= load_en;
    end
    if (load_en) begin
      s1_ptr    <= write_pointer;
      s1_opcode <= opcode;
      s1_a      <= operand_a;
      s1_b      <= operand_b;
    end
  end

  // ALU on sign-extended operands; RES_W = 2*OP_W holds the full product
  logic signed [RES_W-1:0] a_ext;
  logic signed [RES_W-1:0] b_ext;
  logic signed [RES_W-1:0] b_div;
  logic signed [RES_W-1:0] alu_res;
  logic                    alu_div0;

  assign a_ext = {{(RES_W-OP_W){s1_a[OP_W-1]}}, s1_a};
  assign b_ext = {{(RES_W-OP_W){s1_b[OP_W-1]}}, s1_b};
  // Divisor forced to 1 on zero so the divider never sees 0; result is masked anyway
  assign b_div = (b_ext == '0) ? {{(RES_W-1){1'b0}}, 1'b1} : b_ext;

  always_comb begin
    alu_res  = '0;
    alu_div0 = 1'b0;
    case (s1_opcode)
      OP_ZERO:  alu_res = '0;
      OP_PASSA: alu_res = a_ext;
      OP_PASSB: alu_res = b_ext;
      OP_ADD:   alu_res = a_ext + b_ext;
      OP_SUB:   alu_res = a_ext - b_ext;
      OP_MULT:  alu_res = a_ext * b_ext;
      OP_DIV: begin
        if (b_ext == '0) alu_div0 = 1'b1;
        else             alu_res  = a_ext / b_div;
      end
      OP_MOD: begin
        if (b_ext == '0) alu_div0 = 1'b1;
        else             alu_res  = a_ext % b_div;
      end
      default: alu_res = '0;
    endcase
  end

  // Entry storage; contents are qualified by valid_q so no reset is needed
  logic [2:0]       mem_opcode [DEPTH];
  logic [OP_W-1:0]  mem_a      [DEPTH];
  logic [OP_W-1:0]  mem_b      [DEPTH];
  logic [RES_W-1:0] mem_result [DEPTH];
  logic             mem_div0   [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [AW:0]      count_q;

  always_ff @(posedge clk) begin
    if (s1_valid) begin
      mem_opcode[s1_ptr] <= s1_opcode;
      mem_a[s1_ptr]      <= s1_a;
      mem_b[s1_ptr]      <= s1_b;
      mem_result[s1_ptr] <= alu_res;
      mem_div0[s1_ptr]   <= alu_div0;
    end
  end

  // Clear takes priority over a commit at the same edge; the commit is dropped
  always_ff @(posedge clk) begin
    if (reset || clear_en) begin
      valid_q <= '0;
      count_q <= '0;
    end else if (s1_valid) begin
      valid_q[s1_ptr] <= 1'b1;
      if (!valid_q[s1_ptr]) begin
        count_q <= count_q + (AW+1)'(1);
      end
    end
  end

  // Read port samples pre-edge state, giving read-before-write on collisions
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid     <= 1'b0;
      rd_hit       <= 1'b0;
      rd_opcode    <= '0;
      rd_operand_a <= '0;
      rd_operand_b <= '0;
      rd_result    <= '0;
      rd_div0      <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_hit <= valid_q[read_pointer];
        if (valid_q[read_pointer]) begin
          rd_opcode    <= mem_opcode[read_pointer];
          rd_operand_a <= mem_a[read_pointer];
          rd_operand_b <= mem_b[read_pointer];
          rd_result    <= mem_result[read_pointer];
          rd_div0      <= mem_div0[read_pointer];
        end else begin
          rd_opcode    <= '0;
          rd_operand_a <= '0;
          rd_operand_b <= '0;
          rd_result    <= '0;
          rd_div0      <= 1'b0;
        end
      end
    end
  end

  assign entry_count = count_q;
  assign full        = (count_q == (AW+1)'(DEPTH));

endmodule

// File: tb/tb_instr_register_pipe.sv
// tb/tb_instr_register_pipe.sv - self-checking bench for instr_register_pipe
module tb_instr_register_pipe;

  localparam logic [2:0] ZERO = 3'd0, PASSA = 3'd1, PASSB = 3'd2, ADD = 3'd3,
                         SUB = 3'd4, MULT = 3'd5, DIV = 3'd6, MOD = 3'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_en;
  logic [4:0]  write_pointer;
  logic [2:0]  opcode;
  logic [7:0]  operand_a;
  logic [7:0]  operand_b;
  logic        clear_en;
  logic        rd_en;
  logic [4:0]  read_pointer;
  logic        rd_valid;
  logic        rd_hit;
  logic [2:0]  rd_opcode;
  logic [7:0]  rd_operand_a;
  logic [7:0]  rd_operand_b;
  logic [15:0] rd_result;
  logic        rd_div0;
  logic [5:0]  entry_count;
  logic        full;

  instr_register_pipe dut (
    .clk(clk), .reset(reset), .load_en(load_en), .write_pointer(write_pointer),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .clear_en(clear_en), .rd_en(rd_en), .read_pointer(read_pointer),
    .rd_valid(rd_valid), .rd_hit(rd_hit), .rd_opcode(rd_opcode),
    .rd_operand_a(rd_operand_a), .rd_operand_b(rd_operand_b),
    .rd_result(rd_result), .rd_div0(rd_div0),
    .entry_count(entry_count), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ptr;
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        div0;
  } vec_t;

  typedef struct {
    logic        hit;
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        div0;
  } rd_exp_t;

  int vectors    = 0;
  int miscompares = 0;
  rd_exp_t sb[$];
  logic issued = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    load_en  = 1'b0;
    clear_en = 1'b0;
    rd_en    = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] p, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    load_en       = 1'b1;
    write_pointer = p;
    opcode        = op;
    operand_a     = a;
    operand_b     = b;
  endtask

  task automatic set_read(input logic [4:0] p, input logic hit, input logic [2:0] op,
                          input logic [7:0] a, input logic [7:0] b, input logic [15:0] res, input logic div0);
    rd_exp_t e;
    rd_en        = 1'b1;
    read_pointer = p;
    e.hit = hit; e.op = op; e.a = a; e.b = b; e.res = res; e.div0 = div0;
    sb.push_back(e);
  endtask

  // Every accepted read must produce exactly one rd_valid pulse the next cycle
  always @(posedge clk) issued <= rd_en && !reset;

  always @(negedge clk) begin
    if (!reset) begin
      check("rd_valid_pulse", 64'(rd_valid), 64'(issued));
      if (rd_valid && issued) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
          rd_exp_t e;
          e = sb.pop_front();
          check("rd_hit",       64'(rd_hit),       64'(e.hit));
          check("rd_opcode",    64'(rd_opcode),    64'(e.op));
          check("rd_operand_a", 64'(rd_operand_a), 64'(e.a));
          check("rd_operand_b", 64'(rd_operand_b), 64'(e.b));
          check("rd_result",    64'(rd_result),    64'(e.res));
          check("rd_div0",      64'(rd_div0),      64'(e.div0));
        end
      end
    end
  end

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{5'd3,  ADD,   8'hFB, 8'd7,  16'd2,     1'b0};
    vecs[1]  = '{5'd4,  MULT,  8'h80, 8'h80, 16'd16384, 1'b0};
    vecs[2]  = '{5'd5,  DIV,   8'hF9, 8'd2,  16'hFFFD,  1'b0};
    vecs[3]  = '{5'd6,  MOD,   8'hF9, 8'd2,  16'hFFFF,  1'b0};
    vecs[4]  = '{5'd7,  DIV,   8'd9,  8'd0,  16'd0,     1'b1};
    vecs[5]  = '{5'd8,  MOD,   8'd9,  8'd0,  16'd0,     1'b1};
    vecs[6]  = '{5'd9,  SUB,   8'd3,  8'h80, 16'd131,   1'b0};
    vecs[7]  = '{5'd11, DIV,   8'h80, 8'hFF, 16'd128,   1'b0};
    vecs[8]  = '{5'd12, MOD,   8'd7,  8'hFD, 16'd1,     1'b0};
    vecs[9]  = '{5'd13, ZERO,  8'd5,  8'd6,  16'd0,     1'b0};
    vecs[10] = '{5'd14, PASSB, 8'd1,  8'hF7, 16'hFFF7,  1'b0};

    reset = 1'b1;
    write_pointer = '0; opcode = '0; operand_a = '0; operand_b = '0; read_pointer = '0;
    idle();
    step();
    step();
    reset = 1'b0;
    check("reset_rd_valid",    64'(rd_valid),    64'd0);
    check("reset_rd_result",   64'(rd_result),   64'd0);
    check("reset_entry_count", 64'(entry_count), 64'd0);
    check("reset_full",        64'(full),        64'd0);

    // Every address misses after reset
    for (int p = 0; p < 32; p++) begin
      set_read(5'(p), 1'b0, 3'd0, 8'd0, 8'd0, 16'd0, 1'b0);
      step();
    end
    idle();
    step();
    check("empty_count", 64'(entry_count), 64'd0);

    // ALU table: load, commit, read two edges after the load
    for (int i = 0; i < 11; i++) begin
      set_load(vecs[i].ptr, vecs[i].op, vecs[i].a, vecs[i].b);
      step();
      idle();
      step();
      set_read(vecs[i].ptr, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].div0);
      step();
      idle();
      check("table_count", 64'(entry_count), 64'(i + 1));
    end
    step();

    // Reset with a write in flight: commit is discarded, outputs zeroed
    set_load(5'd15, PASSA, 8'd77, 8'd0);
    step();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset_rd_result", 64'(rd_result),   64'd0);
    check("midreset_count",     64'(entry_count), 64'd0);
    set_read(5'd15, 1'b0, 3'd0, 8'd0, 8'd0, 16'd0, 1'b0);
    step();
    set_read(5'd3, 1'b0, 3'd0, 8'd0, 8'd0, 16'd0, 1'b0);
    step();
    idle();
    step();

    // Read/write hazard on ptr 10
    set_load(5'd10, PASSA, 8'd1, 8'd0);
    step();
    set_load(5'd10, PASSB, 8'd0, 8'd2);
    step();
    idle();
    set_read(5'd10, 1'b1, PASSA, 8'd1, 8'd0, 16'd1, 1'b0);
    step();
    set_read(5'd10, 1'b1, PASSB, 8'd0, 8'd2, 16'd2, 1'b0);
    step();
    idle();
    check("hazard_count", 64'(entry_count), 64'd1);

    // Plain clear
    clear_en = 1'b1;
    step();
    idle();
    check("clear_count", 64'(entry_count), 64'd0);

    // Back-to-back fill of all addresses
    for (int p = 0; p < 32; p++) begin
      set_load(5'(p), ADD, 8'(p), 8'd1);
      step();
    end
    idle();
    check("fill31_count", 64'(entry_count), 64'd31);
    check("fill31_full",  64'(full),        64'd0);
    step();
    check("fill_count", 64'(entry_count), 64'd32);
    check("fill_full",  64'(full),        64'd1);
    set_read(5'd17, 1'b1, ADD, 8'd17, 8'd1, 16'd18, 1'b0);
    step();
    idle();

    // Overwrite while full
    set_load(5'd0, PASSA, 8'd100, 8'd0);
    step();
    idle();
    step();
    check("rewrite_count", 64'(entry_count), 64'd32);
    check("rewrite_full",  64'(full),        64'd1);
    set_read(5'd0, 1'b1, PASSA, 8'd100, 8'd0, 16'd100, 1'b0);
    step();
    idle();

    // Clear drops the commit at its edge, keeps the load, read sees pre-clear data
    set_load(5'd2, PASSB, 8'd0, 8'd33);
    step();
    set_load(5'd1, PASSA, 8'd55, 8'd0);
    clear_en = 1'b1;
    set_read(5'd5, 1'b1, ADD, 8'd5, 8'd1, 16'd6, 1'b0);
    step();
    idle();
    check("clear_load_count", 64'(entry_count), 64'd0);
    check("clear_load_full",  64'(full),        64'd0);
    step();
    check("post_clear_count", 64'(entry_count), 64'd1);
    set_read(5'd0, 1'b0, 3'd0, 8'd0, 8'd0, 16'd0, 1'b0);
    step();
    set_read(5'd2, 1'b0, 3'd0, 8'd0, 8'd0, 16'd0, 1'b0);
    step();
    set_read(5'd1, 1'b1, PASSA, 8'd55, 8'd0, 16'd55, 1'b0);
    step();
    idle();
    step();
    step();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_register_pipe.md
Name: instr_register_pipe

Overview:
Parametrised next-generation instruction register. Each accepted write carries an opcode and two signed operands. A registered ALU stage computes the result, and the block stores opcode, operands, result and a divide-by-zero flag into a DEPTH-entry array. The block tracks per-entry valid bits, occupancy and bulk clear, and provides a registered read port with a valid strobe. It sits between the stimulus/driver side and the checker/scoreboard side of the instruction-register test environment.

Parameters:
DEPTH, 32, number of entries; power of 2, at least 2
OP_W, 8, operand width in bits; signed, at least 2
AW, $clog2(DEPTH), pointer width; derived, not overridden
RES_W, 2*OP_W, result width; derived, signed

Ports:
clk  in  1  clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
load_en  in  1  write request; accepted every cycle it is high
write_pointer  in  AW  write address
opcode  in  3  0 ZERO, 1 PASSA, 2 PASSB, 3 ADD, 4 SUB, 5 MULT, 6 DIV, 7 MOD
operand_a  in  OP_W  signed operand A
operand_b  in  OP_W  signed operand B
clear_en  in  1  invalidate all entries
rd_en  in  1  read request
read_pointer  in  AW  read address
rd_valid  out  1  read data valid; one-cycle pulse
rd_hit  out  1  addressed entry was valid
rd_opcode  out  3  stored opcode
rd_operand_a  out  OP_W  stored operand A
rd_operand_b  out  OP_W  stored operand B
rd_result  out  RES_W  stored result
rd_div0  out  1  stored divide/modulo-by-zero flag
entry_count  out  AW+1  number of valid entries
full  out  1  entry_count == DEPTH

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (port reset).
- While reset is high at a rising edge:
  - all valid bits cleared; array contents are don't-care
  - pipeline stage valid cleared
  - rd_valid, rd_hit, rd_div0, entry_count, full = 0
  - rd_opcode, rd_operand_a, rd_operand_b, rd_result = 0
- Reset mid-operation discards any in-flight write; no partial commit occurs.
- Write pipeline, 2 stages:
  - Edge N with load_en=1: capture pointer, opcode and operands into stage 1.
  - Edge N+1: ALU result computed from stage 1, entry written, valid bit set.
  - Sustained load_en gives one commit per cycle; there is no backpressure.
- ALU, operands sign-extended to RES_W:
  - ZERO -> 0
  - PASSA -> a
  - PASSB -> b
  - ADD -> a+b
  - SUB -> a-b
  - MULT -> a*b (full product, never overflows RES_W)
  - DIV -> a/b, truncated toward zero
  - MOD -> a%b, sign follows the dividend
  - DIV or MOD with b==0 -> result 0, div0=1. div0=0 for every other case.
- Read:
  - Edge M with rd_en=1 samples the entry as of before edge M.
  - Registered outputs are updated at edge M, with rd_valid=1 for exactly the following cycle.
  - rd_valid=0 when rd_en=0; data outputs hold their last value.
  - Invalid entry: rd_hit=0 and rd_opcode/operands/result/div0 = 0.
- Read/write hazard:
  - A commit at edge N+1 is visible to reads sampled at edge N+2 or later.
  - A read and a commit to the same address at the same edge return the old contents (read-before-write). No forwarding.
- Occupancy:
  - entry_count +1 on a commit to an invalid entry.
  - Unchanged on overwrite of a valid entry.
  - Never exceeds DEPTH. full asserts in the same cycle the count reaches DEPTH.
  - Writes while full are allowed; they can only overwrite.
- Clear:
  - clear_en=1 at an edge clears all valid bits and sets entry_count=0.
  - clear wins over the commit occurring at that edge (discarded).
  - A load accepted at the same edge is kept and commits at the next edge.
  - A read sampled at the clear edge sees pre-clear contents.
- Pointers use exactly AW bits; there is no wrap logic beyond natural truncation.

Test Plan:
- Reset, then rd_en at every address 0..31 -> rd_valid pulses once per read; rd_hit=0; all data 0; entry_count=0.
- Write ptr 3: ADD a=-5 b=7; read ptr 3 two edges after the load -> rd_result=2, rd_hit=1, rd_div0=0, entry_count=1.
- Write ptr 4: MULT a=-128 b=-128 -> rd_result=16384. Write ptr 5: DIV a=-7 b=2 -> -3. Write ptr 6: MOD a=-7 b=2 -> -1.
- Write ptr 7: DIV a=9 b=0 -> rd_result=0, rd_div0=1. Write ptr 8: MOD a=9 b=0 -> rd_result=0, rd_div0=1.
- Hazard check:
  - Write ptr 10 PASSA a=1, then PASSB b=2 to ptr 10 on the next cycle.
  - Read ptr 10 at the edge of the second commit -> rd_result=1; read one cycle later -> 2.
  - entry_count ends at 1.
- Back-to-back writes to all 32 addresses -> full=1, entry_count=32.
  - Rewrite ptr 0 -> count stays 32.
  - clear_en together with load_en at ptr 1 -> count 0, then 1 at the next edge.
  - Read ptr 0 -> rd_hit=0.
